// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the 32-point FFT pass scheduler.
// The stride table is a right shift of the first-pass butterfly span.
package fft_sched_pkg;

   localparam int N     = 32;
   localparam int LOG2N = 5;

   // First pass spans N/2. Each later pass halves the span: 16, 8, 4, 2, 1.
   localparam logic [4:0] STRIDE_MAX = 5'(N / 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_OUT  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/fft_pass_counter.sv
// Nested intra-pass cycle counter and pass (stage) index.
// The index holds at the last pass so it stays stable while the result is presented.
module fft_pass_counter #(
   parameter int p_stages     = 5,
   parameter int p_passCycles = 5,
   parameter int p_stageBits  = 3,
   parameter int p_cntBits    = 3
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   clr,
   input  logic                   en,
   output logic [p_stageBits-1:0] stage,
   output logic                   last_cycle,
   output logic                   last_pass
);

   localparam logic [p_cntBits-1:0]   LAST_CNT   = p_cntBits'(p_passCycles - 1);
   localparam logic [p_stageBits-1:0] LAST_STAGE = p_stageBits'(p_stages - 1);

   logic [p_cntBits-1:0] cnt;

   assign last_cycle = (cnt == LAST_CNT);
   assign last_pass  = (stage == LAST_STAGE);

   // Clear wins over enable so an abort or a fresh frame always restarts at pass 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt   <= '0;
         stage <= '0;
      end else if (clr) begin
         cnt   <= '0;
         stage <= '0;
      end else if (en) begin
         if (last_cycle) begin
            cnt <= '0;
            if (!last_pass) stage <= stage + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fft32_pass_scheduler.sv
// Steps one shared radix-2 stage datapath through all passes of a 32-point FFT in place.
// Handshakes: a transfer happens on an edge where valid and ready are both high; o_valid holds until i_ready.
module fft32_pass_scheduler
   import fft_sched_pkg::*;
#(
   parameter int p_stages     = 5,
   parameter int p_passCycles = 5,
   parameter int p_stageBits  = 3,
   parameter int p_cntBits    = 3
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_abort,
   output logic                   o_ld_in,
   output logic                   o_wr_en,
   output logic [p_stageBits-1:0] o_stage,
   output logic [4:0]             o_stride,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_busy,
   output logic [15:0]            o_frames
);

   sched_state_t state;
   sched_state_t next_state;

   logic cnt_clr;
   logic cnt_en;
   logic last_cycle;
   logic last_pass;

   fft_pass_counter #(
      .p_stages     (p_stages),
      .p_passCycles (p_passCycles),
      .p_stageBits  (p_stageBits),
      .p_cntBits    (p_cntBits)
   ) u_counter (
      .CLK        (CLK),
      .RST        (RST),
      .clr        (cnt_clr),
      .en         (cnt_en),
      .stage      (o_stage),
      .last_cycle (last_cycle),
      .last_pass  (last_pass)
   );

   assign o_stride = STRIDE_MAX >> o_stage;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Abort beats both accept and write-back; in IDLE there is nothing to abort.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (i_valid) next_state = ST_PASS;
         ST_PASS: begin
            if (i_abort)                      next_state = ST_IDLE;
            else if (last_cycle && last_pass) next_state = ST_OUT;
         end
         ST_OUT: begin
            if (i_abort)      next_state = ST_IDLE;
            else if (i_ready) next_state = i_valid ? ST_PASS : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == ST_IDLE) || ((state == ST_OUT) && i_ready);
      o_ld_in = i_valid && o_ready;
      o_valid = (state == ST_OUT);
      o_busy  = (state != ST_IDLE);
      o_wr_en = (state == ST_PASS) && last_cycle;
      cnt_en  = (state == ST_PASS) && !i_abort;
      // Restart the counters on every (re)entry to PASS and whenever the frame is dropped.
      cnt_clr = (next_state == ST_IDLE) ||
                ((next_state == ST_PASS) && (state != ST_PASS));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         o_frames <= '0;
      else if ((state == ST_OUT) && i_ready && !i_abort)
         o_frames <= o_frames + 16'd1;
   end

endmodule

// File: tb/tb_fft32_pass_scheduler.sv
// Directed bench for fft32_pass_scheduler: a time-since-accept model checked every cycle,
// plus literal checks on latency, strides, backpressure, back-to-back, abort and async reset.
module tb_fft32_pass_scheduler;

   localparam int STAGES = 5;
   localparam int P      = 5;
   localparam int LAT    = STAGES * P;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic        i_abort;
   logic        o_ld_in;
   logic        o_wr_en;
   logic [2:0]  o_stage;
   logic [4:0]  o_stride;
   logic        o_valid;
   logic        i_ready;
   logic        o_busy;
   logic [15:0] o_frames;

   fft32_pass_scheduler dut (
      .CLK      (clk),
      .RST      (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_abort  (i_abort),
      .o_ld_in  (o_ld_in),
      .o_wr_en  (o_wr_en),
      .o_stage  (o_stage),
      .o_stride (o_stride),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_busy   (o_busy),
      .o_frames (o_frames)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
   endtask

   // ---------------- model: clocks elapsed since accept ----------------
   // m_t < 0: idle; 0..LAT-1: passes running; LAT: result presented.
   int          m_t;
   logic [15:0] m_frames;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t      <= -1;
         m_frames <= '0;
      end else if (m_t >= 0 && i_abort) begin
         m_t <= -1;
      end else if (m_t < 0) begin
         if (i_valid) m_t <= 0;
      end else if (m_t < LAT) begin
         m_t <= m_t + 1;
      end else if (i_ready) begin
         m_frames <= m_frames + 16'd1;
         m_t      <= i_valid ? 0 : -1;
      end
   end

   // ---------------- scoreboard / per-cycle compare ----------------
   int          wr_q[$];
   logic [4:0]  str_q[$];
   logic [4:0]  exp_q[$];
   int          hs_q[$];
   int          ld_hs;

   always @(negedge clk) begin
      int es;
      int rdy;
      es  = (m_t < 0) ? 0 : (m_t >= LAT) ? STAGES - 1 : m_t / P;
      rdy = ((m_t < 0) || (m_t == LAT && i_ready)) ? 1 : 0;
      check("ready",  o_ready,  rdy);
      check("ld_in",  o_ld_in,  (i_valid && rdy) ? 1 : 0);
      check("wr_en",  o_wr_en,  (m_t >= 0 && m_t < LAT && (m_t % P) == P - 1) ? 1 : 0);
      check("stage",  o_stage,  es);
      check("stride", o_stride, 16 >> es);
      check("valid",  o_valid,  (m_t == LAT) ? 1 : 0);
      check("busy",   o_busy,   (m_t >= 0) ? 1 : 0);
      check("frames", o_frames, m_frames);
      if (o_wr_en) begin
         wr_q.push_back(edge_n + 1);
         str_q.push_back(o_stride);
      end
      if (o_valid && i_ready) hs_q.push_back(edge_n + 1);
      if (o_ld_in && o_valid) ld_hs++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_frame(output int at);
      i_valid = 1'b1;
      tick();
      at = edge_n;
      i_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (o_valid) begin
            at = edge_n;
            break;
         end
      end
      if (at < 0) check("valid_timeout", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      int vat;
      rst = 1'b1; i_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b0; ld_hs = 0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_ready",  o_ready,  1);
      check("rst_valid",  o_valid,  0);
      check("rst_busy",   o_busy,   0);
      check("rst_stage",  o_stage,  0);
      check("rst_stride", o_stride, 16);
      check("rst_frames", o_frames, 0);
      rst = 1'b0;
      repeat (3) tick();

      // single frame, strides 16..1 at write-backs 5 clocks apart
      i_ready = 1'b1;
      wr_q.delete(); str_q.delete();
      exp_q = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};
      accept_frame(acc);
      wait_valid(40, vat);
      check("single_latency", vat - acc, 25);
      check("single_wr_count", wr_q.size(), 5);
      for (int i = 0; i < 5 && wr_q.size() > 0; i++)
         check("single_wr_edge", wr_q.pop_front() - acc, 5 * (i + 1));
      while (exp_q.size() > 0 && str_q.size() > 0)
         check("single_wr_stride", str_q.pop_front(), exp_q.pop_front());
      tick();
      check("single_valid_drop", o_valid, 0);
      check("single_frames", o_frames, 1);

      // backpressure
      i_ready = 1'b0;
      accept_frame(acc);
      wait_valid(40, vat);
      check("bp_latency", vat - acc, 25);
      wr_q.delete();
      repeat (12) begin
         tick();
         check("bp_valid", o_valid, 1);
         check("bp_stage", o_stage, 4);
         check("bp_ready", o_ready, 0);
      end
      check("bp_no_wr", wr_q.size(), 0);
      i_ready = 1'b1;
      tick();
      check("bp_frames", o_frames, 2);
      check("bp_idle", o_busy, 0);

      // back-to-back, four frames
      hs_q.delete(); ld_hs = 0;
      i_valid = 1'b1;
      for (int i = 0; i < 200 && hs_q.size() < 4; i++) begin
         tick();
         if (hs_q.size() == 3) i_valid = 1'b0;
      end
      i_valid = 1'b0;
      check("b2b_handshakes", hs_q.size(), 4);
      for (int i = 0; i + 1 < hs_q.size(); i++)
         check("b2b_interval", hs_q[i + 1] - hs_q[i], 26);
      check("b2b_ld_coincident", ld_hs, 3);
      check("b2b_frames", o_frames, 6);
      check("b2b_idle", o_busy, 0);

      // abort at cnt=2 of stage 3
      accept_frame(acc);
      repeat (17) tick();
      check("abort_pre_stage", o_stage, 3);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_stage", o_stage, 0);
      check("abort_frames", o_frames, 6);
      wr_q.delete();
      repeat (30) tick();
      check("abort_no_wr", wr_q.size(), 0);
      accept_frame(acc);
      wait_valid(40, vat);
      check("post_abort_latency", vat - acc, 25);
      tick();
      check("post_abort_frames", o_frames, 7);

      // async reset in stage 2
      accept_frame(acc);
      repeat (12) tick();
      check("arst_pre_stage", o_stage, 2);
      #2 rst = 1'b1;
      #1;
      check("arst_ready",  o_ready,  1);
      check("arst_valid",  o_valid,  0);
      check("arst_busy",   o_busy,   0);
      check("arst_wr",     o_wr_en,  0);
      check("arst_stage",  o_stage,  0);
      check("arst_stride", o_stride, 16);
      check("arst_frames", o_frames, 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("arst_after_frames", o_frames, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
